memory_access_controller: RTL
=============================

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, extra RAM access cycles per transfer (legal 0..15).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port clr  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req  input  1  transfer request, level; sampled only in IDLE.
REQ-005 SHALL have port we  input  1  1 = write (bus to RAM), 0 = read (RAM to bus); sampled with req.
REQ-006 SHALL have port ram_ready  input  1  RAM completion strobe; used only when MEMCTL_RAM_READY_EN is defined.
REQ-007 SHALL have port mar_load  output  1  load address register from bus.
REQ-008 SHALL have port mdr_enable  output  1  data-register enable.
REQ-009 SHALL have port mdr_ctrl  output  2  data-register op: 00 load bus, 01 load RAM, 10 drive bus, 11 drive RAM.
REQ-010 SHALL have port mdr_clr  output  1  data-register clear; equals clr.
REQ-011 SHALL have port ram_we  output  1  RAM write strobe.
REQ-012 SHALL have port ram_oe  output  1  RAM output enable.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL be a Moore FSM; all outputs decode from the state register and wait counter only. No input-to-output combinational path except mdr_clr.
REQ-016 SHALL use states IDLE, ADDR, WLOAD, WRITE, WDONE, RWAIT, RCAPT, RDRIVE.
REQ-017 IDLE: all outputs 0. If req=1, go to ADDR and latch we.
REQ-018 ADDR: mar_load=1, one cycle. Go to WLOAD if latched we=1, else to RWAIT.
REQ-019 WLOAD: mdr_enable=1, mdr_ctrl=00, one cycle. Go to WRITE.
REQ-020 WRITE: mdr_enable=1, mdr_ctrl=11, ram_we=1 for WAIT_STATES+1 cycles. Go to WDONE.
REQ-021 WDONE: done=1, one cycle. Go to IDLE.
REQ-022 RWAIT: ram_oe=1 for WAIT_STATES+1 cycles. Go to RCAPT.
REQ-023 RCAPT: ram_oe=1, mdr_enable=1, mdr_ctrl=01, one cycle. Go to RDRIVE.
REQ-024 RDRIVE: mdr_enable=1, mdr_ctrl=10, done=1, one cycle. Go to IDLE. The requester samples read data on this cycle.
REQ-025 Write latency from req accept to done SHALL be WAIT_STATES+4 cycles; read latency SHALL be WAIT_STATES+4 cycles.
REQ-026 The wait counter SHALL be 4 bits. It loads WAIT_STATES on entry to WRITE/RWAIT and decrements to 0; exit occurs on the cycle the count is 0. WAIT_STATES=0 gives exactly one cycle.
REQ-027 Deasserting req or changing we mid-transfer SHALL be ignored; the transfer completes.
REQ-028 If req is held high through done, the next transfer SHALL begin with one IDLE cycle between transfers.
REQ-029 mdr_enable and ram_we SHALL never both be high with mdr_ctrl other than 11. ram_we and ram_oe SHALL never both be high.

Reset
REQ-030 clr=1 SHALL force IDLE and wait counter 0 on the next edge from any state; the in-flight transfer is abandoned with no done pulse.
REQ-031 While clr=1, mdr_clr=1; all other outputs reach 0 by the cycle after clr is sampled.

Configuration
REQ-032 Macro MEMCTL_RAM_READY_EN defined: WRITE and RWAIT SHALL hold until ram_ready=1 is sampled (minimum one cycle) and WAIT_STATES SHALL be ignored. Undefined: ram_ready SHALL be unused and fixed WAIT_STATES timing applies.

Structure
REQ-033 Package memctl_pkg SHALL hold the state enumeration and the mdr_ctrl encodings (MDR_LD_BUS=00, MDR_LD_RAM=01, MDR_DRV_BUS=10, MDR_DRV_RAM=11).
REQ-034 The wait counter SHALL be a sub-module, memctl_wait_timer (load, decrement, zero flag).

Verification
REQ-035 Write, WAIT_STATES=2: req=1, we=1 in IDLE -> mar_load cycle 1, mdr_ctrl=00 cycle 2, ram_we cycles 3-5, done cycle 6.
REQ-036 Read, WAIT_STATES=0: req=1, we=0 -> ram_oe cycles 2-3, mdr_ctrl=01 cycle 3, done with mdr_ctrl=10 cycle 4.
REQ-037 Reset mid-transfer: clr=1 during WRITE -> ram_we=0 and busy=0 on the next cycle, no done, mdr_clr=1 while clr is high.
REQ-038 Back-to-back: req held high for two reads -> exactly one IDLE cycle between the two done pulses.
REQ-039 MEMCTL_RAM_READY_EN defined: ram_ready held 0 for 5 cycles in RWAIT -> ram_oe stays high; ram_ready=1 -> RCAPT on the next cycle.
REQ-040 Protocol checks across all runs: ram_we and ram_oe never both high, and done is never high for more than one consecutive cycle.

Source files
------------

// File: rtl/memctl_pkg.sv
// Shared types for the memory access controller: FSM states, MDR op codes, output decode.
// The decode function is the single place that defines what each state drives.
package memctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WLOAD,
        WRITE,
        WDONE,
        RWAIT,
        RCAPT,
        RDRIVE
    } state_t;

    localparam logic [1:0] MDR_LD_BUS  = 2'b00;
    localparam logic [1:0] MDR_LD_RAM  = 2'b01;
    localparam logic [1:0] MDR_DRV_BUS = 2'b10;
    localparam logic [1:0] MDR_DRV_RAM = 2'b11;

    typedef struct packed {
        logic       mar_load;
        logic       mdr_enable;
        logic [1:0] mdr_ctrl;
        logic       ram_we;
        logic       ram_oe;
        logic       busy;
        logic       done;
    } ctl_t;

    function automatic ctl_t state_outputs(input state_t s);
        ctl_t c;
        c      = '0;
        c.busy = (s != IDLE);
        case (s)
            ADDR:   c.mar_load = 1'b1;
            WLOAD:  begin c.mdr_enable = 1'b1; c.mdr_ctrl = MDR_LD_BUS; end
            WRITE:  begin c.mdr_enable = 1'b1; c.mdr_ctrl = MDR_DRV_RAM; c.ram_we = 1'b1; end
            WDONE:  c.done = 1'b1;
            RWAIT:  c.ram_oe = 1'b1;
            RCAPT:  begin c.ram_oe = 1'b1; c.mdr_enable = 1'b1; c.mdr_ctrl = MDR_LD_RAM; end
            RDRIVE: begin c.mdr_enable = 1'b1; c.mdr_ctrl = MDR_DRV_BUS; c.done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/memctl_wait_timer.sv
// 4-bit wait-state down-counter: load, decrement to zero, zero flag.
// Latency: zero reflects the registered count; no backpressure.
// Synchronous clear forces the count to 0.
module memctl_wait_timer (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/memory_access_controller.sv
// Moore FSM sequencing MAR/MDR/RAM strobes for one bus transfer; outputs registered per state.
// Latency: WAIT_STATES+4 cycles from req accept to done; req sampled only in IDLE, no backpressure.
// Build option MEMCTL_RAM_READY_EN: WRITE/RWAIT hold until ram_ready instead of WAIT_STATES.
module memory_access_controller
    import memctl_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic       we,
    input  logic       ram_ready,
    output logic       mar_load,
    output logic       mdr_enable,
    output logic [1:0] mdr_ctrl,
    output logic       mdr_clr,
    output logic       ram_we,
    output logic       ram_oe,
    output logic       busy,
    output logic       done
);

    state_t state;
    state_t nxt;
    ctl_t   ctl;
    logic   we_l;
    logic   tmr_load;
    logic   tmr_dec;
    logic   tmr_zero;
    logic   xfer_end;

    // Reload on entry into either timed state; count while resident in it.
    assign tmr_load = (state == WLOAD) || (state == ADDR && !we_l);
    assign tmr_dec  = (state == WRITE) || (state == RWAIT);

    memctl_wait_timer u_wait_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (4'(WAIT_STATES)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

`ifdef MEMCTL_RAM_READY_EN
    logic unused_tmr_zero;
    assign unused_tmr_zero = tmr_zero;
    assign xfer_end        = ram_ready;
`else
    logic unused_ram_ready;
    assign unused_ram_ready = ram_ready;
    assign xfer_end         = tmr_zero;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = ADDR;
            ADDR:    nxt = we_l ? WLOAD : RWAIT;
            WLOAD:   nxt = WRITE;
            WRITE:   if (xfer_end) nxt = WDONE;
            WDONE:   nxt = IDLE;
            RWAIT:   if (xfer_end) nxt = RCAPT;
            RCAPT:   nxt = RDRIVE;
            RDRIVE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            ctl   <= '0;
            we_l  <= 1'b0;
        end else begin
            state <= nxt;
            ctl   <= state_outputs(nxt);
            if (state == IDLE && req)
                we_l <= we;
        end
    end

    assign mar_load   = ctl.mar_load;
    assign mdr_enable = ctl.mdr_enable;
    assign mdr_ctrl   = ctl.mdr_ctrl;
    assign ram_we     = ctl.ram_we;
    assign ram_oe     = ctl.ram_oe;
    assign busy       = ctl.busy;
    assign done       = ctl.done;
    assign mdr_clr    = clr;

endmodule
